// File: rtl/pio_fifo_pair_pkg.sv
// pio_fifo_pair_pkg
// Shared types for the paired PIO FIFO:
//   fifo_status  - packed {empty, full} status pair
//   fifo_mode_t  - storage sharing mode (normal, TX joined, RX joined)
//   decode_mode  - maps the two join inputs onto a mode
package pio_fifo_pair_pkg;

  typedef struct packed {
    logic empty;
    logic full;
  } fifo_status;

  typedef enum logic [1:0] {
    FIFO_NORMAL  = 2'd0,
    FIFO_JOIN_TX = 2'd1,
    FIFO_JOIN_RX = 2'd2
  } fifo_mode_t;

  // Requesting both joins at once is meaningless, so it falls back to NORMAL.
  function automatic fifo_mode_t decode_mode(input logic join_tx, input logic join_rx);
    case ({join_tx, join_rx})
      2'b10:   return FIFO_JOIN_TX;
      2'b01:   return FIFO_JOIN_RX;
      default: return FIFO_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/pio_fifo_pair_fifo_ctrl.sv
// fifo_ctrl
// Pointer/occupancy controller for one FIFO direction; storage lives in the
// parent. A capacity of 0 describes a disabled FIFO: it then reads as both
// empty and full, so every push and pop is refused without extra logic.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   capacity [CW]   current number of usable entries (0, DEPTH or 2*DEPTH)
//   push, pop       requests (already masked by the parent for mode changes)
//   flush           clear pointers and count at the next edge
//   head, tail      read / write pointers relative to this FIFO's base
//   count [CW]      registered occupancy
//   empty, full     count == 0, count == capacity
module fifo_ctrl #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] capacity,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-2:0] head,
  output logic [CW-2:0] tail,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [CW-2:0] head_reg, head_next;
  logic [CW-2:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic          push_ok, pop_ok;

  // Pointers wrap at the current capacity rather than at the pointer width,
  // because an unjoined FIFO only owns half of the shared array.
  function automatic logic [CW-2:0] wrap_inc(input logic [CW-2:0] ptr,
                                             input logic [CW-1:0] cap);
    if ({1'b0, ptr} == cap - CW'(1)) return '0;
    return ptr + (CW-1)'(1);
  endfunction

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == capacity);
  assign pop_ok = pop && !empty;
  // A push into a full FIFO still goes ahead when a pop frees the slot.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (push_ok) tail_next = wrap_inc(tail_reg, capacity);
    if (pop_ok)  head_next = wrap_inc(head_reg, capacity);
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign head  = head_reg;
  assign tail  = tail_reg;
  assign count = count_reg;

endmodule

// File: rtl/pio_fifo_pair.sv
// pio_fifo_pair
// Paired TX/RX FIFO for one PIO state machine. Both FIFOs share a single
// 2*DEPTH-entry array; in NORMAL mode TX owns the lower half and RX the upper
// half, and a joined FIFO owns the whole array while the other is disabled.
// Any change of the decoded join mode flushes both FIFOs.
// Optional feature macro: PIO_FIFO_FLAGS_EN adds sticky overflow/underflow
// flags and a flags_clear input.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   join_tx, join_rx                 storage-sharing requests
//   tx_push_en, tx_data_in           external bus write into TX
//   tx_pop_en, tx_data_out           state machine read from TX (fall-through)
//   tx_status, tx_count              {empty, full}, occupancy
//   tx_thresh, tx_level_hit          low-water level, tx_count < tx_thresh
//   rx_*                             mirror; rx_level_hit = rx_count >= rx_thresh
//   flags_clear, tx/rx_overflow/underflow  (PIO_FIFO_FLAGS_EN only)
module pio_fifo_pair
  import pio_fifo_pair_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(2*DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             join_tx,
  input  logic             join_rx,
  input  logic             tx_push_en,
  input  logic [WIDTH-1:0] tx_data_in,
  input  logic             tx_pop_en,
  output logic [WIDTH-1:0] tx_data_out,
  output fifo_status       tx_status,
  output logic [CW-1:0]    tx_count,
  input  logic [CW-1:0]    tx_thresh,
  output logic             tx_level_hit,
  input  logic             rx_push_en,
  input  logic [WIDTH-1:0] rx_data_in,
  input  logic             rx_pop_en,
  output logic [WIDTH-1:0] rx_data_out,
  output fifo_status       rx_status,
  output logic [CW-1:0]    rx_count,
  input  logic [CW-1:0]    rx_thresh,
  output logic             rx_level_hit
`ifdef PIO_FIFO_FLAGS_EN
  ,
  input  logic             flags_clear,
  output logic             tx_overflow,
  output logic             tx_underflow,
  output logic             rx_overflow,
  output logic             rx_underflow
`endif
);

  localparam int PW = CW - 1;
  localparam logic [CW-1:0] CAP_HALF = CW'(DEPTH);
  localparam logic [CW-1:0] CAP_FULL = CW'(2*DEPTH);

  fifo_mode_t mode_decoded, mode_q;
  logic       mode_chg;

  logic [CW-1:0] tx_cap, rx_cap;
  logic [PW-1:0] tx_head, tx_tail, rx_head, rx_tail, rx_base;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push_g, tx_pop_g, rx_push_g, rx_pop_g;
  logic          tx_wr, rx_wr;

  logic [WIDTH-1:0] mem [2*DEPTH];

  assign mode_decoded = decode_mode(join_tx, join_rx);
  // rst already flushes everything, so a change is only reported outside it.
  assign mode_chg = (mode_decoded != mode_q) && !rst;

  // The registered mode is simply the previous decode; loading during rst
  // means the first cycle out of reset never looks like a mode change.
  always_ff @(posedge clk) begin
    mode_q <= mode_decoded;
  end

  always_comb begin
    tx_cap  = CAP_HALF;
    rx_cap  = CAP_HALF;
    rx_base = PW'(DEPTH);
    case (mode_q)
      FIFO_JOIN_TX: begin
        tx_cap = CAP_FULL;
        rx_cap = '0;
      end
      FIFO_JOIN_RX: begin
        tx_cap  = '0;
        rx_cap  = CAP_FULL;
        rx_base = '0;
      end
      default: ;
    endcase
  end

  assign tx_push_g = tx_push_en && !mode_chg && !rst;
  assign tx_pop_g  = tx_pop_en  && !mode_chg && !rst;
  assign rx_push_g = rx_push_en && !mode_chg && !rst;
  assign rx_pop_g  = rx_pop_en  && !mode_chg && !rst;

  fifo_ctrl #(.CW(CW)) u_tx_ctrl (
    .clk      (clk),
    .rst      (rst),
    .capacity (tx_cap),
    .push     (tx_push_g),
    .pop      (tx_pop_g),
    .flush    (mode_chg),
    .head     (tx_head),
    .tail     (tx_tail),
    .count    (tx_count),
    .empty    (tx_empty),
    .full     (tx_full)
  );

  fifo_ctrl #(.CW(CW)) u_rx_ctrl (
    .clk      (clk),
    .rst      (rst),
    .capacity (rx_cap),
    .push     (rx_push_g),
    .pop      (rx_pop_g),
    .flush    (mode_chg),
    .head     (rx_head),
    .tail     (rx_tail),
    .count    (rx_count),
    .empty    (rx_empty),
    .full     (rx_full)
  );

  // Same acceptance rule as inside fifo_ctrl: a full FIFO takes a word only
  // when it also gives one up, and then the tail slot is the vacated head.
  assign tx_wr = tx_push_g && (!tx_full || (tx_pop_g && !tx_empty));
  assign rx_wr = rx_push_g && (!rx_full || (rx_pop_g && !rx_empty));

  // TX always starts at entry 0, so only RX needs a base offset. In NORMAL
  // mode the two regions are disjoint; in a joined mode only one side writes.
  always_ff @(posedge clk) begin
    if (tx_wr) mem[tx_tail] <= tx_data_in;
    if (rx_wr) mem[rx_base + rx_tail] <= rx_data_in;
  end

  assign tx_data_out = tx_empty ? '0 : mem[tx_head];
  assign rx_data_out = rx_empty ? '0 : mem[rx_base + rx_head];

  assign tx_status = '{empty: tx_empty, full: tx_full};
  assign rx_status = '{empty: rx_empty, full: rx_full};

  assign tx_level_hit = (mode_q != FIFO_JOIN_RX) && (tx_count <  tx_thresh);
  assign rx_level_hit = (mode_q != FIFO_JOIN_TX) && (rx_count >= rx_thresh);

`ifdef PIO_FIFO_FLAGS_EN
  logic tx_ovf_set, tx_udf_set, rx_ovf_set, rx_udf_set;

  // Requests swallowed by a mode change are not errors, hence the mode_chg
  // term. A disabled FIFO is empty and full, so anything sent to it counts.
  assign tx_ovf_set = tx_push_en && !mode_chg && tx_full && !(tx_pop_en && !tx_empty);
  assign tx_udf_set = tx_pop_en  && !mode_chg && tx_empty;
  assign rx_ovf_set = rx_push_en && !mode_chg && rx_full && !(rx_pop_en && !rx_empty);
  assign rx_udf_set = rx_pop_en  && !mode_chg && rx_empty;

  // A new event outranks flags_clear on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
      rx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      tx_overflow  <= tx_ovf_set | (tx_overflow  & ~flags_clear);
      tx_underflow <= tx_udf_set | (tx_underflow & ~flags_clear);
      rx_overflow  <= rx_ovf_set | (rx_overflow  & ~flags_clear);
      rx_underflow <= rx_udf_set | (rx_underflow & ~flags_clear);
    end
  end
`endif

endmodule

// File: tb/tb_pio_fifo_pair.sv
// tb_pio_fifo_pair
// Directed bench for pio_fifo_pair (WIDTH=32, DEPTH=4). Inputs change and
// outputs are sampled 1 time unit after each rising edge. Flag checks are
// compiled in when PIO_FIFO_FLAGS_EN is defined.
module tb_pio_fifo_pair;
  import pio_fifo_pair_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(2*DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             join_tx, join_rx;
  logic             tx_push_en, tx_pop_en, rx_push_en, rx_pop_en;
  logic [WIDTH-1:0] tx_data_in, rx_data_in, tx_data_out, rx_data_out;
  fifo_status       tx_status, rx_status;
  logic [CW-1:0]    tx_count, rx_count, tx_thresh, rx_thresh;
  logic             tx_level_hit, rx_level_hit;
`ifdef PIO_FIFO_FLAGS_EN
  logic             flags_clear;
  logic             tx_overflow, tx_underflow, rx_overflow, rx_underflow;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pio_fifo_pair #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .join_tx      (join_tx),
    .join_rx      (join_rx),
    .tx_push_en   (tx_push_en),
    .tx_data_in   (tx_data_in),
    .tx_pop_en    (tx_pop_en),
    .tx_data_out  (tx_data_out),
    .tx_status    (tx_status),
    .tx_count     (tx_count),
    .tx_thresh    (tx_thresh),
    .tx_level_hit (tx_level_hit),
    .rx_push_en   (rx_push_en),
    .rx_data_in   (rx_data_in),
    .rx_pop_en    (rx_pop_en),
    .rx_data_out  (rx_data_out),
    .rx_status    (rx_status),
    .rx_count     (rx_count),
    .rx_thresh    (rx_thresh),
    .rx_level_hit (rx_level_hit)
`ifdef PIO_FIFO_FLAGS_EN
    ,
    .flags_clear  (flags_clear),
    .tx_overflow  (tx_overflow),
    .tx_underflow (tx_underflow),
    .rx_overflow  (rx_overflow),
    .rx_underflow (rx_underflow)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_push_en = 1'b0; tx_pop_en = 1'b0;
    rx_push_en = 1'b0; rx_pop_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; join_tx = 1'b0; join_rx = 1'b0;
    idle();
    tx_data_in = '0; rx_data_in = '0;
    tx_thresh = '0; rx_thresh = '0;
`ifdef PIO_FIFO_FLAGS_EN
    flags_clear = 1'b0;
`endif
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_tx_status", tx_status, 2'b10);
    check("rst_rx_status", rx_status, 2'b10);
    check("rst_tx_count", tx_count, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_tx_data", tx_data_out, 0);
    check("rst_tx_lvl_thr0", tx_level_hit, 1'b0);
    check("rst_rx_lvl_thr0", rx_level_hit, 1'b1);

    // Fill TX with A1..A5; A5 must be dropped
    for (int i = 0; i < 5; i++) begin
      tx_push_en = 1'b1; tx_data_in = 32'hA1 + i;
      step();
      if (i == 0) check("tx_first_head", tx_data_out, 32'hA1);
    end
    idle();
    check("tx_fill_count", tx_count, 4);
    check("tx_fill_status", tx_status, 2'b01);

    for (int i = 0; i < 4; i++) begin
      check("tx_pop_data", tx_data_out, 32'hA1 + i);
      tx_pop_en = 1'b1;
      step();
    end
    idle();
    check("tx_drain_status", tx_status, 2'b10);
    check("tx_drain_data", tx_data_out, 0);
    tx_pop_en = 1'b1; step(); idle();
    check("tx_pop_empty_count", tx_count, 0);

    // Full TX: push B0 and pop together
    for (int i = 0; i < 4; i++) begin
      tx_push_en = 1'b1; tx_data_in = 32'hA1 + i;
      step();
    end
    tx_push_en = 1'b1; tx_pop_en = 1'b1; tx_data_in = 32'hB0;
    step(); idle();
    check("tx_full_pp_count", tx_count, 4);
    check("tx_full_pp_head", tx_data_out, 32'hA2);
    for (int i = 0; i < 4; i++) begin
      check("tx_full_pp_order", tx_data_out, (i == 3) ? 32'hB0 : 32'hA2 + i);
      tx_pop_en = 1'b1; step();
    end
    idle();
    check("tx_full_pp_empty", tx_count, 0);

    // Empty RX: push and pop together -> only push happens
    rx_push_en = 1'b1; rx_pop_en = 1'b1; rx_data_in = 32'hC1;
    check("rx_pp_before", rx_data_out, 0);
    step(); idle();
    check("rx_pp_count", rx_count, 1);
    check("rx_pp_data", rx_data_out, 32'hC1);
    rx_pop_en = 1'b1; step(); idle();
    check("rx_pp_drain", rx_count, 0);

    // Put a word in TX, then join TX: everything flushed
    tx_push_en = 1'b1; tx_data_in = 32'h55; step(); idle();
    join_tx = 1'b1; tx_push_en = 1'b1; tx_data_in = 32'h66;
    step(); idle();
    check("jtx_flush_count", tx_count, 0);
    check("jtx_rx_status", rx_status, 2'b11);
    check("jtx_rx_count", rx_count, 0);
    check("jtx_rx_lvl", rx_level_hit, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tx_push_en = 1'b1; tx_data_in = 32'hD0 + i;
      step();
      if (i == 6) check("jtx_7_status", tx_status, 2'b00);
    end
    idle();
    check("jtx_8_count", tx_count, 8);
    check("jtx_8_status", tx_status, 2'b01);
    rx_push_en = 1'b1; rx_data_in = 32'hEE; step(); idle();
    check("jtx_rx_push_ign", rx_count, 0);
    // Pop 3, push 3 more so the tail wraps through entry 0
    for (int i = 0; i < 3; i++) begin
      check("jtx_pop", tx_data_out, 32'hD0 + i);
      tx_pop_en = 1'b1; step();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      tx_push_en = 1'b1; tx_data_in = 32'hD8 + i; step();
    end
    idle();
    check("jtx_wrap_count", tx_count, 8);
    for (int i = 0; i < 8; i++) begin
      check("jtx_wrap_data", tx_data_out, 32'hD3 + i);
      tx_pop_en = 1'b1; step();
    end
    idle();
    check("jtx_wrap_empty", tx_status, 2'b10);

    // Back to NORMAL; RX level and TX level
    join_tx = 1'b0; step();
    check("norm_rx_status", rx_status, 2'b10);
    rx_thresh = 3; tx_thresh = 2;
    for (int i = 0; i < 3; i++) begin
      rx_push_en = 1'b1; rx_data_in = 32'hF1 + i; step();
      if (i == 1) check("rx_lvl_2", rx_level_hit, 1'b0);
    end
    idle();
    check("rx_lvl_3", rx_level_hit, 1'b1);
    check("rx_norm_head", rx_data_out, 32'hF1);
    check("tx_lvl_0_thr2", tx_level_hit, 1'b1);
    tx_push_en = 1'b1; tx_data_in = 32'h11; step();
    tx_push_en = 1'b1; tx_data_in = 32'h12; step(); idle();
    check("tx_lvl_2_thr2", tx_level_hit, 1'b0);
    tx_pop_en = 1'b1; step(); idle();
    check("tx_lvl_1_thr2", tx_level_hit, 1'b1);

    // Toggle join_rx with a push in the same cycle
    join_rx = 1'b1; rx_push_en = 1'b1; rx_data_in = 32'h99;
    step(); idle();
    check("jrx_rx_count", rx_count, 0);
    check("jrx_tx_count", tx_count, 0);
    check("jrx_tx_status", tx_status, 2'b11);
    check("jrx_tx_lvl", tx_level_hit, 1'b0);
    check("jrx_rx_lvl", rx_level_hit, 1'b0);
    rx_push_en = 1'b1; rx_data_in = 32'h77; step(); idle();
    check("jrx_rx_data", rx_data_out, 32'h77);

    // Both joins -> NORMAL (mode change flushes)
    join_tx = 1'b1; step();
    check("both_tx_status", tx_status, 2'b10);
    check("both_rx_status", rx_status, 2'b10);
    for (int i = 0; i < 5; i++) begin
      rx_push_en = 1'b1; rx_data_in = 32'h30 + i;
      tx_push_en = 1'b1; tx_data_in = 32'h20 + i;
      step();
    end
    idle();
    check("both_tx_count", tx_count, 4);
    check("both_rx_count", rx_count, 4);
    check("both_tx_head", tx_data_out, 32'h20);
    check("both_rx_head", rx_data_out, 32'h30);

    // Reset mid-operation, with a push in the same cycle
    rst = 1'b1; tx_push_en = 1'b1; tx_pop_en = 1'b1; step();
    rst = 1'b0; idle();
    check("mid_rst_tx_count", tx_count, 0);
    check("mid_rst_rx_count", rx_count, 0);
    check("mid_rst_tx_data", tx_data_out, 0);

`ifdef PIO_FIFO_FLAGS_EN
    join_tx = 1'b0; join_rx = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    check("flg_rst", {tx_overflow, tx_underflow, rx_overflow, rx_underflow}, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tx_push_en = 1'b1; tx_data_in = 32'h40 + i; step();
    end
    check("flg_no_ovf", tx_overflow, 1'b0);
    step(); idle();
    check("flg_tx_ovf", tx_overflow, 1'b1);
    step();
    check("flg_tx_ovf_hold", tx_overflow, 1'b1);
    rx_pop_en = 1'b1; step(); idle();
    check("flg_rx_udf", rx_underflow, 1'b1);
    flags_clear = 1'b1; tx_push_en = 1'b1; step(); idle();
    flags_clear = 1'b0;
    check("flg_set_wins", tx_overflow, 1'b1);
    check("flg_rx_cleared", rx_underflow, 1'b0);
    flags_clear = 1'b1; step(); flags_clear = 1'b0;
    check("flg_tx_cleared", tx_overflow, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
